// File: rtl/change_dispenser_pkg.sv
// change_dispenser_pkg
//   Shared definitions for the change dispenser: the FSM state encoding,
//   default electromechanical timing, the coin-count width, and small
//   constant helpers used to size the shared down-counter.
package change_dispenser_pkg;

  // Change is expressed in unit coins, 0..7.
  localparam int COIN_W = 3;

  // Default configuration.
  localparam int DEF_DEPTH   = 4;
  localparam int DEF_PULSE_W = 3;
  localparam int DEF_GAP_W   = 2;
  localparam int DEF_TIMEOUT = 20;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_VEND_ON   = 3'd1,
    ST_VEND_GAP  = 3'd2,
    ST_COIN_ON   = 3'd3,
    ST_COIN_WAIT = 3'd4,
    ST_COIN_GAP  = 3'd5,
    ST_FAULT     = 3'd6
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  // Counter is loaded with (duration - 1) and runs down to zero, so it only
  // has to hold max_val - 1.
  function automatic int cnt_width(input int max_val);
    return (max_val > 1) ? $clog2(max_val) : 1;
  endfunction

endpackage

// File: rtl/change_dispenser_sync_fifo.sv
// change_dispenser_sync_fifo
//   Single-clock FIFO holding queued sales (their change amounts).
//   A push is accepted when the FIFO is not full, or when a pop happens on
//   the same edge (the freed slot is reused immediately).
//
// Ports:
//   clk    in   system clock
//   reset  in   synchronous, active-high; flushes the FIFO
//   push   in   write request
//   pop    in   read request (ignored when empty)
//   wdata  in   WIDTH-bit entry to write
//   rdata  out  head entry (valid when !empty)
//   full   out  occupancy == DEPTH
//   empty  out  occupancy == 0
//   count  out  registered occupancy, $clog2(DEPTH)+1 bits
module change_dispenser_sync_fifo
  import change_dispenser_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int WIDTH = COIN_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; entries are only read after being written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/change_dispenser.sv
// change_dispenser
//   Downstream stage of the vending FSM. Each single-cycle dispense strobe
//   queues a sale; sales are then played out as a timed product-release
//   pulse followed by one timed eject pulse per unit coin of change. After
//   every coin the hopper must acknowledge via coin_sense; a missing
//   acknowledge latches a fault that only reset clears.
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   synchronous, active-high
//   d           in   dispense strobe, one cycle per sale
//   r[2:0]      in   change in unit coins, sampled with d
//   coin_sense  in   hopper coin-sense acknowledge
//   vend        out  product-release pulse (registered)
//   coin_out    out  unit-coin eject pulse (registered)
//   busy        out  sale in progress (registered)
//   pending     out  queued sales not yet started
//   overflow    out  sticky: a sale was dropped on a full queue
//   fault       out  sticky: coin_sense timeout
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_IDLE      | waiting; pops the next sale as soon as the queue has one
// ST_VEND_ON   | vend high for PULSE_W cycles
// ST_VEND_GAP  | GAP_W low cycles after the product pulse
// ST_COIN_ON   | coin_out high for PULSE_W cycles; early acks are latched
// ST_COIN_WAIT | waiting up to TIMEOUT cycles for the coin acknowledge
// ST_COIN_GAP  | GAP_W low cycles after an acknowledged coin
// ST_FAULT     | hopper jam; outputs parked, queue still accepts sales
module change_dispenser
  import change_dispenser_pkg::*;
#(
  parameter int DEPTH   = DEF_DEPTH,
  parameter int PULSE_W = DEF_PULSE_W,
  parameter int GAP_W   = DEF_GAP_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   d,
  input  logic [COIN_W-1:0]      r,
  input  logic                   coin_sense,
  output logic                   vend,
  output logic                   coin_out,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] pending,
  output logic                   overflow,
  output logic                   fault
);

  localparam int CNT_MAX = max3(PULSE_W, GAP_W, TIMEOUT);
  localparam int CNT_W   = cnt_width(CNT_MAX);

  localparam logic [CNT_W-1:0] LD_PULSE   = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] LD_GAP     = CNT_W'(GAP_W - 1);
  localparam logic [CNT_W-1:0] LD_TIMEOUT = CNT_W'(TIMEOUT - 1);

  state_t            state_q;
  state_t            state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [COIN_W-1:0] rem_q;
  logic [COIN_W-1:0] rem_d;
  logic              ack_q;
  logic              ack_d;
  logic              cnt_zero;
  logic              pop;

  logic [COIN_W-1:0] fifo_rdata;
  logic              fifo_full;
  logic              fifo_empty;

  change_dispenser_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (COIN_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (d),
    .pop   (pop),
    .wdata (r),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (pending)
  );

  assign cnt_zero = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    ack_d   = ack_q;
    pop     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          rem_d   = fifo_rdata;
          state_d = ST_VEND_ON;
          cnt_d   = LD_PULSE;
        end
      end

      ST_VEND_ON: begin
        if (cnt_zero) begin
          state_d = ST_VEND_GAP;
          cnt_d   = LD_GAP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ST_VEND_GAP, ST_COIN_GAP: begin
        if (cnt_zero) begin
          if (rem_q != '0) begin
            state_d = ST_COIN_ON;
            cnt_d   = LD_PULSE;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ST_COIN_ON: begin
        // A fast hopper may answer while the eject pulse is still high.
        if (coin_sense) ack_d = 1'b1;
        if (cnt_zero) begin
          state_d = ST_COIN_WAIT;
          cnt_d   = LD_TIMEOUT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ST_COIN_WAIT: begin
        // An acknowledge on the final timeout cycle still counts.
        if (ack_q || coin_sense) begin
          rem_d   = rem_q - 1'b1;
          state_d = ST_COIN_GAP;
          cnt_d   = LD_GAP;
        end else if (cnt_zero) begin
          state_d = ST_FAULT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ST_FAULT: begin
        state_d = ST_FAULT;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Each coin starts with a clean acknowledge.
    if (state_d == ST_COIN_ON && state_q != ST_COIN_ON) ack_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      ack_q   <= ack_d;
    end
  end

  // Outputs are decoded from the next state so they are true flops that
  // change on the same edge as the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      vend     <= 1'b0;
      coin_out <= 1'b0;
      busy     <= 1'b0;
      fault    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      vend     <= (state_d == ST_VEND_ON);
      coin_out <= (state_d == ST_COIN_ON);
      busy     <= (state_d != ST_IDLE) && (state_d != ST_FAULT);
      fault    <= (state_d == ST_FAULT);
      if (d && fifo_full && !pop) overflow <= 1'b1;
    end
  end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
Downstream stage of the vending FSM. Consumes its per-sale dispense strobe d and change amount r[2:0], and queues each sale.
Drives the product-release actuator and the unit-coin hopper ejector with timed pulses. Waits for a hopper coin-sense acknowledge after every coin and latches a fault on a jam.
Decouples the single-cycle FSM outputs from slow electromechanical timing.

Parameters:
DEPTH, 4, sale FIFO entries; power of 2, at least 2
PULSE_W, 3, cycles vend/coin_out held high per pulse; at least 1
GAP_W, 2, low cycles between consecutive pulses; at least 1
TIMEOUT, 20, max cycles from coin_out fall to coin_sense before fault; at least 1

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high
d  input  1  dispense strobe from vending FSM, one cycle per sale
r  input  3  change in unit coins, sampled with d (0..7)
coin_sense  input  1  hopper sensor, high at least 1 cycle per ejected coin
vend  output  1  product-release pulse
coin_out  output  1  unit-coin eject pulse
busy  output  1  high in any state other than IDLE or FAULT
pending  output  $clog2(DEPTH)+1  number of queued sales not yet started
overflow  output  1  sticky: a sale was dropped because the FIFO was full
fault  output  1  sticky: coin_sense timeout

Behaviour:
- Decided interface: one clock, clk; reset is synchronous and active-high, port named reset.
- Reset: all outputs 0, FIFO flushed, state IDLE. A reset mid-pulse drops vend/coin_out at the same edge; no resumption.
- Push: on an edge with d=1, {r} is written if the FIFO is not full, or if a pop occurs on the same edge. Otherwise the sale is dropped and overflow=1 until reset. r is ignored when d=0.
- pending = FIFO occupancy; it updates at the edge of each push/pop.
- All outputs are registered.
- FSM states: IDLE, VEND_ON, VEND_GAP, COIN_ON, COIN_WAIT, COIN_GAP, FAULT.
- IDLE: if the FIFO is non-empty, pop the head into rem[2:0], go to VEND_ON, and load the counter.
  - Latency: d high at edge N into an empty FIFO in IDLE -> vend high from edge N+1.
- VEND_ON: vend=1 for PULSE_W cycles, then VEND_GAP.
- VEND_GAP: low for GAP_W cycles, then COIN_ON if rem != 0, else IDLE.
- COIN_ON: coin_out=1 for PULSE_W cycles, then COIN_WAIT.
  - A coin_sense high seen during COIN_ON is latched as the acknowledge.
- COIN_WAIT: on an acknowledge (latched or present), decrement rem and go to COIN_GAP.
  - If TIMEOUT cycles elapse with no acknowledge, go to FAULT.
- COIN_GAP: GAP_W low cycles, then COIN_ON if rem != 0, else IDLE.
- The acknowledge latch clears on entering COIN_ON. Extra coin_sense pulses outside COIN_ON/COIN_WAIT are ignored.
- FAULT: fault=1, vend=coin_out=busy=0, no pops. Pushes continue (overflow still tracked). Exit only by reset.
- A back-to-back sale goes IDLE->VEND_ON on the first cycle back in IDLE, giving one idle cycle between sales.
- The single down-counter is sized for max(PULSE_W, GAP_W, TIMEOUT).

Decomposition:
- Shared package: state encoding constants, default timing constants, and coin-unit width (3).
- One natural sub-module: sync_fifo (parameter DEPTH, WIDTH=3; push/pop/full/empty/count). FSM, counter and rem stay in the top.

Test Plan:
1. reset 1 cycle; d=1,r=0 one cycle -> vend high exactly 3 cycles starting next edge, coin_out never high, busy falls after the gap, pending returns to 0.
2. d=1,r=3; coin_sense pulsed 2 cycles after each coin_out fall -> 3 coin_out pulses of 3 cycles, each separated by wait+2 gap cycles, fault=0.
3. d=1,r=2; coin_sense held low -> one coin_out pulse, fault=1 exactly 20 cycles after its fall, busy=0, no second pulse.
4. Five sales d=1 on consecutive cycles while the first is in VEND_ON -> pending saturates at 4, overflow=1, and the remaining 4 sales are dispensed in order with the r values preserved.
5. reset asserted in the middle of a coin_out pulse -> coin_out, busy, pending and fault are 0 at the same edge, and a new sale afterwards dispenses normally.
6. coin_sense high during COIN_ON only -> acknowledge accepted, no fault, rem decrements.
